// File: rtl/clock_pkg.sv
// Shared constants, types and helpers for the alarm-clock timekeeping digits.
package clock_pkg;

    localparam int unsigned SEC_MOD    = 60;
    localparam int unsigned MIN_MOD    = 60;
    localparam int unsigned HOUR24_MOD = 24;
    localparam int unsigned HOUR12_MOD = 12;
    localparam int unsigned DIGIT_W    = 6;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_RESET,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } cnt_op_e;

    // Valid only for 0..99; callers guarantee the range.
    function automatic bcd2_t to_bcd2(input logic [6:0] v);
        bcd2_t r;
        r.tens  = 4'(v / 7'd10);
        r.units = 4'(v % 7'd10);
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd2.sv
// Combinational binary (0..99) to two-digit BCD conversion.
module bin_to_bcd2
    import clock_pkg::*;
#(
    parameter int unsigned WIDTH = 6
) (
    input  logic [WIDTH-1:0] bin_i,
    output bcd2_t            bcd_o
);

    always_comb begin
        bcd_o = to_bcd2(7'(bin_i));
    end

endmodule

// File: rtl/counter_mod.sv
// Modulo-N up/down counter digit with load, clamp and combinational carry/borrow-out.
// Optional registered BCD output enabled by macro COUNTER_BCD_EN.
module counter_mod
    import clock_pkg::*;
#(
    parameter int unsigned MODULUS = 60,
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             c,
    input  logic             dir,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    output logic [WIDTH-1:0] count,
    output logic             co,
`ifdef COUNTER_BCD_EN
    output logic [7:0]       bcd,
`endif
    output logic             zero
);

    // Compares run at WIDTH+1 bits so MODULUS == 2**WIDTH stays representable.
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TOP_W = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] TOP_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("counter_mod: MODULUS out of range 2..2**WIDTH");
    end
    if (RST_VAL >= MODULUS) begin : g_bad_rst_val
        $error("counter_mod: RST_VAL must be below MODULUS");
    end

    logic [WIDTH-1:0] count_q, count_d;
    cnt_op_e          op;
    logic             at_top, at_zero;

    assign at_top  = ({1'b0, count_q} == TOP_W);
    assign at_zero = (count_q == '0);

    always_comb begin
        op = OP_HOLD;
        if (!rst)      op = OP_RESET;
        else if (ld)   op = OP_LOAD;
        else if (c)    op = dir ? OP_DOWN : OP_UP;
    end

    always_comb begin
        count_d = count_q;
        unique case (op)
            OP_RESET: count_d = RST_V;
            OP_LOAD:  count_d = ({1'b0, ld_val} < MOD_W) ? ld_val : TOP_V;
            OP_UP:    count_d = at_top  ? '0    : count_q + 1'b1;
            OP_DOWN:  count_d = at_zero ? TOP_V : count_q - 1'b1;
            default:  count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) count_q <= RST_V;
        else      count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = at_zero;
    assign co    = ((op == OP_UP) && at_top) || ((op == OP_DOWN) && at_zero);

`ifdef COUNTER_BCD_EN
    if (MODULUS > 100) begin : g_bad_bcd_mod
        $error("counter_mod: BCD output requires MODULUS <= 100");
    end

    bcd2_t bcd_d, bcd_q;

    bin_to_bcd2 #(.WIDTH(WIDTH)) u_bcd (
        .bin_i (count_q),
        .bcd_o (bcd_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) bcd_q <= to_bcd2(7'(RST_VAL));
        else      bcd_q <= bcd_d;
    end

    assign bcd = bcd_q;
`endif

endmodule
